divider: RTL and testbench

//  Sequential 32-bit signed integer divider for the CPU's DIV instruction; counterpart of the

---
 rtl/divider_pkg.sv | 14 +
 rtl/div_sign_fix.sv | 18 +
 rtl/divider.sv | 148 ++++++++++++++
 tb/tb_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: widths and FSM state encoding.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: gives |x| when neg_i is the sign bit, and
// applies the result sign after the magnitude division.
module div_sign_fix
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Wraps modulo 2^WIDTH, so the most negative value maps onto itself as an exact magnitude.
  assign res_o = neg_i ? (~val_i + ONE) : val_i;

endmodule

// File: rtl/divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per
// clock, then sign correction. Quotient on lo, remainder on hi.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     a_shift, trial;

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvd (
    .val_i (dividend), .neg_i (dividend[WIDTH-1]), .res_o (dvd_abs)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvs (
    .val_i (divisor), .neg_i (divisor[WIDTH-1]), .res_o (dvs_abs)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i (q_q), .neg_i (neg_quo_q), .res_o (quo_fix)
  );
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i (a_q), .neg_i (neg_rem_q), .res_o (rem_fix)
  );

  // A stays below M <= 2^(WIDTH-1), so the shifted remainder always fits in WIDTH+1 bits.
  assign a_shift = {a_q, q_q[WIDTH-1]};
  assign trial   = a_shift - {1'b0, m_q};

  // NOTE: every _d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = S_ZERO;
          end else begin
            q_d       = dvd_abs;
            m_d       = dvs_abs;
            a_d       = '0;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            cnt_d     = '0;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        q_d    = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        a_d    = trial[WIDTH] ? a_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = quo_fix;
        hi_d    = rem_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divider.sv
// Bench for the sequential divider: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed quotient/remainder.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: truncating signed division in 64-bit arithmetic, low bits kept.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: an accepted request completes a fixed number of edges later.
  bit          m_pend = 0, m_zero = 0, m_done = 0, m_dz = 0, m_busy = 0;
  int          m_cyc = 0, m_start_cyc = 0, m_done_at = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_pend = 0; m_done = 0; m_dz = 0; m_busy = 0; m_hi = '0; m_lo = '0;
    end else begin
      bit          accept;
      logic [63:0] r;
      m_cyc++;
      accept = !m_pend && start;
      m_done = 0;
      m_dz   = 0;
      if (m_pend && m_cyc == m_done_at) begin
        m_pend = 0;
        m_done = 1;
        m_dz   = m_zero;
        if (!m_zero) begin
          m_hi = m_res_hi;
          m_lo = m_res_lo;
        end
      end
      if (accept) begin
        m_pend      = 1;
        m_start_cyc = m_cyc;
        m_zero      = (divisor == 0);
        m_done_at   = m_cyc + (m_zero ? 1 : 33);
        if (!m_zero) begin
          r        = model_div(dividend, divisor);
          m_res_lo = r[31:0];
          m_res_hi = r[63:32];
        end
      end
      m_busy = m_pend && !m_zero && (m_cyc > m_start_cyc);
    end
  end

  bit cmp_en = 0;
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (cmp_en) begin
      check("model.busy", 32'(busy), 32'(m_busy));
      check("model.done", 32'(done), 32'(m_done));
      check("model.div_zero", 32'(div_zero), 32'(m_dz));
      check("model.hi", hi, m_hi);
      check("model.lo", lo, m_lo);
    end
  end

  // Waits (bounded) for done; cyc = number of edges after the reference point.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) check({name, ".timeout"}, 32'(cyc), 32'(0));
  endtask

  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input bit exp_zero, input string name);
    int cyc;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    wait_done(name, cyc);
    check({name, ".latency"}, 32'(cyc), exp_zero ? 32'd1 : 32'd33);
    check({name, ".lo"}, lo, exp_lo);
    check({name, ".hi"}, hi, exp_hi);
    check({name, ".div_zero"}, 32'(div_zero), 32'(exp_zero));
    check({name, ".busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, snap;

    repeat (2) @(negedge clk);
    cmp_en = 1;
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    reset = 1'b0;

    run_op(32'd7, 32'd2, 32'd3, 32'd1, 0, "7/2");
    run_op(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "-7/2");
    run_op(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 0, "7/-2");
    run_op(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 0, "-7/-2");
    run_op(32'h1234 * 32'h1236, 32'h1235, 32'h1234, 32'h1234, 0, "prime_1234");
    run_op(32'd5, 32'd0, 32'h1234, 32'h1234, 1, "5/0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, "min/-1");
    run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 0, "min/1");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 0, "max/min");
    run_op(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, "-100/7");
    run_op(32'd3, 32'd7, 32'd0, 32'd3, 0, "3/7");

    // start held high across done: a second operation begins on the idle edge
    @(negedge clk);
    dividend = 32'd20; divisor = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done("held1", cyc);
    check("held1.lo", lo, 32'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("held2", cyc);
    check("held2.latency", 32'(cyc), 32'd33);
    check("held2.hi", hi, 32'd2);
    @(negedge clk);

    // start pulse while busy is ignored
    snap = done_cnt;
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", cyc);
    repeat (40) @(negedge clk);
    check("busy_start.done_count", 32'(done_cnt - snap), 32'd1);
    check("busy_start.lo", lo, 32'd14);
    check("busy_start.hi", hi, 32'd2);

    // reset mid-run abandons the operation
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    snap = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("midreset.hi", hi, 32'd0);
    check("midreset.lo", lo, 32'd0);
    check("midreset.busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset.no_done", 32'(done_cnt - snap), 32'd0);
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 0, "9/3");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
